mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter DATA_W, default 8, data width in bits.
REQ-003 Parameter LATENCY, default 3, cycles from request acceptance to ack; legal range 1..15.
REQ-004 Port clk  input  1  clock; all state changes on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port rd_req  input  1  read request, sampled only when busy=0.
REQ-007 Port wr_req  input  1  write request, sampled only when busy=0.
REQ-008 Port addr  input  ADDR_W  request address.
REQ-009 Port wr_data  input  DATA_W  write data.
REQ-010 Port rd_data  output  DATA_W  registered read result, valid in the ack cycle and held until the next read completes.
REQ-011 Port busy  output  1  high from the cycle after acceptance through the ack cycle.
REQ-012 Port ack  output  1  single-cycle completion pulse.
REQ-013 Port dbg_wen  input  1  debug write enable.
REQ-014 Port dbg_addr  input  ADDR_W  debug address, shared by debug read and debug write.
REQ-015 Port dbg_wr_data  input  DATA_W  debug write data.
REQ-016 Port dbg_rd_data  output  DATA_W  combinational read of mem[dbg_addr].

Function
REQ-017 Storage SHALL be 2**ADDR_W words of DATA_W bits; contents are not reset.
REQ-018 FSM states SHALL be IDLE, WAIT and DONE.
REQ-019 IDLE: on an edge with rd_req|wr_req, latch op/addr/wr_data, load cnt=LATENCY-1, and go to WAIT; if LATENCY=1, go directly to DONE.
REQ-020 WAIT: cnt decrements each cycle; when cnt=1, go to DONE.
REQ-021 DONE: perform the latched op (write mem, or load rd_data), assert ack for that cycle, and return to IDLE.
REQ-022 ack SHALL be high exactly LATENCY cycles after the accepting edge.
REQ-023 Requests with busy=1 SHALL be ignored, not queued.
REQ-024 rd_req and wr_req both high at acceptance: treat as write; the read is dropped.
REQ-025 Back-to-back: a request present in the ack cycle is not accepted; the earliest acceptance is the edge after ack.
REQ-026 Debug write SHALL occur on any edge with dbg_wen=1, independent of FSM state.
REQ-027 Debug write and DONE write to the same address on the same edge: debug data wins.
REQ-028 A read completing in the same cycle as a debug write to the same address returns the pre-write value.
REQ-029 Address arithmetic SHALL be modulo 2**ADDR_W; cnt width is 4 bits.

Reset
REQ-030 rst low SHALL immediately force state=IDLE, busy=0, ack=0, rd_data=0, cnt=0, and clear latched op/addr/data.
REQ-031 Reset asserted during WAIT or DONE SHALL abort the op; no memory write occurs.
REQ-032 The first request SHALL be accepted no earlier than the first rising edge after rst deasserts.

Structure
REQ-033 Shared package mem_bus_pkg SHALL hold the FSM state enum, the op enum (OP_RD, OP_WR) and default ADDR_W/DATA_W/LATENCY constants.
REQ-034 Storage SHALL be a sub-module mem_resp_store with one write port (debug-priority mux inside), one registered read port and one combinational debug read port.

Verification (LATENCY=3, ADDR_W=DATA_W=8)
REQ-035 Debug write mem[5]=0x2A, then rd_req with addr=5 at t0 -> busy high at t0+1, ack pulse at t0+3 with rd_data=0x2A, busy low at t0+4.
REQ-036 wr_req addr=0x10 data=0x77 -> ack 3 cycles later; dbg_addr=0x10 then shows dbg_rd_data=0x77; mem[0x10] unchanged before the ack cycle.
REQ-037 rd_req held high continuously -> acks every 4 cycles; extra requests during busy produce no additional acks.
REQ-038 rd_req and wr_req both high (addr=3, data=0x55) -> write performed, rd_data unchanged, single ack.
REQ-039 wr_req addr=7 data=0x11 with rst pulsed low in the cycle after acceptance -> no ack, mem[7] keeps its old value, busy=0 while rst is low.
REQ-040 DONE write to addr 9 (0x01) coinciding with dbg_wen writing addr 9 (0x02) -> mem[9]=0x02.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and default sizing for the latency-modelled memory responder.
package mem_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LATENCY = 3;
endpackage

// File: rtl/mem_resp_store.sv
// Word storage: one write port with debug priority, a registered read port
// and a combinational debug read port. Contents are never reset.
module mem_resp_store #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              dbg_wen,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dbg_rd_data
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  // A debug write always takes the single port, even when the FSM also writes.
  assign w_we    = we | dbg_wen;
  assign w_waddr = dbg_wen ? dbg_addr    : waddr;
  assign w_wdata = dbg_wen ? dbg_wr_data : wdata;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rd_data <= '0;
    else if (re) rd_data <= r_mem[raddr];
  end

  assign dbg_rd_data = r_mem[dbg_addr];
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts a read or write when idle and
// completes it with a one-cycle ack exactly LATENCY cycles after acceptance.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              ack,
  input  logic              dbg_wen,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wr_data,
  output logic [DATA_W-1:0] dbg_rd_data
);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            r_state, w_nxt_state;
  logic [3:0]        r_cnt, w_nxt_cnt;
  op_t               r_op, w_nxt_op;
  logic [ADDR_W-1:0] r_addr, w_nxt_addr;
  logic [DATA_W-1:0] r_wdata, w_nxt_wdata;
  logic              w_rd_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_rd_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_RD;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_op    <= w_nxt_op;
      r_addr  <= w_nxt_addr;
      r_wdata <= w_nxt_wdata;
    end
  end

  // Reads load on the edge entering DONE so rd_data is valid in the ack cycle;
  // writes commit on the edge leaving DONE so a reset during DONE cancels them.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_op    = r_op;
    w_nxt_addr  = r_addr;
    w_nxt_wdata = r_wdata;
    w_rd_en     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (rd_req | wr_req) begin
          w_nxt_op    = wr_req ? OP_WR : OP_RD;
          w_nxt_addr  = addr;
          w_nxt_wdata = wr_data;
          w_nxt_cnt   = CNT_INIT;
          if (LATENCY == 1) begin
            w_nxt_state = ST_DONE;
            w_rd_en     = !wr_req;
          end else begin
            w_nxt_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_nxt_cnt = 4'(r_cnt - 4'd1);
        if (r_cnt == 4'd1) begin
          w_nxt_state = ST_DONE;
          w_rd_en     = (r_op == OP_RD);
        end
      end
      ST_DONE: w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // With LATENCY=1 the read is issued on the accepting edge, before r_addr loads.
  assign w_rd_addr = (r_state == ST_IDLE) ? addr : r_addr;
  assign w_mem_we  = (r_state == ST_DONE) && (r_op == OP_WR);
  assign busy      = (r_state != ST_IDLE);
  assign ack       = (r_state == ST_DONE);

  mem_resp_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .we          (w_mem_we),
    .waddr       (r_addr),
    .wdata       (r_wdata),
    .dbg_wen     (dbg_wen),
    .dbg_addr    (dbg_addr),
    .dbg_wr_data (dbg_wr_data),
    .re          (w_rd_en),
    .raddr       (w_rd_addr),
    .rd_data     (rd_data),
    .dbg_rd_data (dbg_rd_data)
  );
endmodule
